muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS core, sitting directly downstream of the register file read ports: operands arrive from rd1/rd2 in the execute stage, and results are held in the architectural HI/LO registers for later MFHI/MFLO. It implements MULT, MULTU, DIV and DIVU in 32 iterations and exposes busy/done so the hazard logic can stall MFHI/MFLO until results are ready. MTHI/MTLO writes are also handled here.

## Interface
- No parameters. Operand width is fixed at 32.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  32  operand A / dividend, from rd1.
- b  input  32  operand B / divisor, from rd2.
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wd  input  32  MTHI/MTLO write data.
- busy  output  1  operation in progress; stall MFHI/MFLO/MULT/DIV while high.
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- States: IDLE, RUN, DONE.
- Reset (any time, including mid-operation): state IDLE, busy 0, done 0, hi 0, lo 0, and the iteration counter and internal working registers are cleared. No partial result is kept.
- IDLE or DONE with start=1: latch op, capture operands, counter=0, go to RUN. For signed ops, capture magnitudes and record the result signs.
- IDLE or DONE with start=0: go or stay IDLE. MTHI/MTLO are honoured.
- RUN: perform one iteration per cycle and increment the counter.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After the 32nd iteration, apply sign correction, write hi/lo, and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless start is accepted.
- start during RUN is ignored. It is not queued.
- hi_we/lo_we during RUN are ignored.
- start and hi_we/lo_we in the same accepting cycle: start wins and the writes are dropped.
- hi_we and lo_we together: both written with wd.
- Multiply results:
  - {hi,lo} = 64-bit product.
  - MULT is signed two's complement. MULTU is unsigned.
- Divide results:
  - lo = quotient, truncated toward zero. hi = remainder, which takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero (b=0), any divide op: completes with normal latency; lo=32'hFFFFFFFF, hi=a.
- Signed overflow (DIV 32'h80000000 by 32'hFFFFFFFF): lo=32'h80000000, hi=0.

## Timing
- start accepted at rising edge N.
- busy=1 from after edge N until after edge N+32.
- hi/lo update at edge N+32. done=1 during cycle N+32..N+33.
- Total latency is 32 cycles from the accepting edge to the result.
- Back-to-back: start held high in DONE is accepted at edge N+33, so the next result lands at N+65.
- MTHI/MTLO: hi/lo update at the same edge that samples hi_we/lo_we. No done pulse.
- busy is registered: it depends only on state, not on the current inputs.
- hi and lo change only on: result commit, accepted MTHI/MTLO, or reset.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 32 cycles hi=32'hFFFFFFFE, lo=32'h00000001, done pulses exactly once, busy high for exactly 32 cycles.
- MULT a=-3 (32'hFFFFFFFD), b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
- DIVU a=100, b=7 -> lo=14, hi=2.
- Divide edge cases:
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
  - DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, same latency.
- Control hazards:
  - During RUN, pulse start with a new op and assert hi_we with wd=32'h1234 -> both ignored; the original result commits.
  - Then in IDLE, hi_we with wd=32'h1234 -> hi=32'h1234 next edge, no done pulse.
  - Drop reset_n at iteration 10 of a MULTU -> hi=lo=0, busy=0, done=0 immediately; no later done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Handles MULT/MULTU (shift-add) and DIV/DIVU (restoring), plus MTHI/MTLO writes.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_signed;
    logic        op_div;
    logic        div_by_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] iter;
    logic [63:0] mul_res;
    logic [31:0] quo_res;
    logic [31:0] rem_res;

    assign op_div      = op[1];
    assign op_signed   = ~op[0];
    assign div_by_zero = op_div && (b == 32'd0);

    // A signed divide by zero is run on the raw dividend with no sign fix-up,
    // so the unsigned datapath naturally yields lo=all-ones and hi=a.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (op_signed && !div_by_zero) begin
            if (a[31]) mag_a = -a;
            if (b[31]) mag_b = -b;
        end
    end

    // One iteration of the active algorithm on the working registers.
    always_comb begin
        mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, dvsr_q} : 33'd0);
        div_diff = prod_q[63:31] - {1'b0, dvsr_q};
        if (is_div_q) begin
            if (div_diff[32]) iter = {prod_q[62:0], 1'b0};
            else              iter = {div_diff[31:0], prod_q[30:0], 1'b1};
        end else begin
            iter = {mul_sum, prod_q[31:1]};
        end
        mul_res = neg_lo_q ? -iter : iter;
        quo_res = neg_lo_q ? -iter[31:0]  : iter[31:0];
        rem_res = neg_hi_q ? -iter[63:32] : iter[63:32];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        prod_d   = prod_q;
        dvsr_d   = dvsr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_RUN: begin
                prod_d = iter;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d  = ST_RUN;
                    cnt_d    = 5'd0;
                    is_div_d = op_div;
                    if (op_div) begin
                        prod_d   = {32'd0, mag_a};
                        dvsr_d   = mag_b;
                        neg_lo_d = op_signed && !div_by_zero && (a[31] ^ b[31]);
                        neg_hi_d = op_signed && !div_by_zero && a[31];
                    end else begin
                        prod_d   = {32'd0, mag_b};
                        dvsr_d   = mag_a;
                        neg_lo_d = op_signed && (a[31] ^ b[31]);
                        neg_hi_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            prod_q   <= 64'd0;
            dvsr_q   <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            prod_q   <= prod_d;
            dvsr_q   <= dvsr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops against an
// arithmetic reference model, and hand-written control/timing sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wd = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the instruction semantics.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p, q, r;
        logic [63:0] ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: begin p = sx * sy; return p; end
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // From the negedge after the accepting edge: count busy cycles until done.
    task automatic wait_done(output int bcycles, output int dcount);
        bcycles = 0;
        dcount  = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                dcount = 1;
                break;
            end
            if (busy) bcycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int bcycles, output int dcount);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bcycles, dcount);
    endtask

    initial begin
        int bc, dc, extra;
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tbl[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[2] = '{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5] = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, bc, dc);
            check($sformatf("tbl%0d busy_cycles", i), bc, 32'd32);
            check($sformatf("tbl%0d done", i), dc, 32'd1);
            check($sformatf("tbl%0d hi", i), hi, tbl[i].hi);
            check($sformatf("tbl%0d lo", i), lo, tbl[i].lo);
            @(negedge clk);
            check($sformatf("tbl%0d done_once", i), {31'd0, done}, 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 4) == 0) rb = -rb;
            if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 20));
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, bc, dc);
            check($sformatf("rnd%0d op%0d %h,%h hi", i, ro, ra, rb), hi, exp[63:32]);
            check($sformatf("rnd%0d op%0d %h,%h lo", i, ro, ra, rb), lo, exp[31:0]);
            check($sformatf("rnd%0d busy_cycles", i), bc, 32'd32);
        end

        // Seed HI with a known value, then run a MULTU with start/MTHI noise mid-run.
        @(negedge clk);
        hi_we = 1'b1; wd = 32'hAAAA5555;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi seed", hi, 32'hAAAA5555);
        @(negedge clk);
        op = 2'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op = 2'd2; a = 32'd100; b = 32'd3; start = 1'b1; hi_we = 1'b1; wd = 32'h1234;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("run mthi ignored", hi, 32'hAAAA5555);
        wait_done(bc, dc);
        check("hazard done", dc, 32'd1);
        check("hazard busy_rest", bc, 32'd27);
        check("hazard hi", hi, 32'd0);
        check("hazard lo", lo, 32'd15);
        @(negedge clk);
        check("hazard no_requeue busy", {31'd0, busy}, 32'd0);

        hi_we = 1'b1; wd = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("idle mthi hi", hi, 32'h1234);
        check("idle mthi lo", lo, 32'd15);
        check("idle mthi done", {31'd0, done}, 32'd0);
        lo_we = 1'b1; wd = 32'hBEEF;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo lo", lo, 32'hBEEF);
        check("mtlo hi", hi, 32'h1234);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h77;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("both hi", hi, 32'h77);
        check("both lo", lo, 32'h77);

        // start wins over MTHI in the same cycle.
        op = 2'd1; a = 32'd2; b = 32'd2; start = 1'b1; hi_we = 1'b1; wd = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("start_wins hi held", hi, 32'h77);
        check("start_wins busy", {31'd0, busy}, 32'd1);
        wait_done(bc, dc);
        check("start_wins hi", hi, 32'd0);
        check("start_wins lo", lo, 32'd4);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        wait_done(bc, dc);
        check("b2b first lo", lo, 32'd42);
        op = 2'd3; a = 32'd50; b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted busy", {31'd0, busy}, 32'd1);
        check("b2b done cleared", {31'd0, done}, 32'd0);
        wait_done(bc, dc);
        check("b2b second busy_cycles", bc, 32'd32);
        check("b2b second hi", hi, 32'd2);
        check("b2b second lo", lo, 32'd6);

        // Asynchronous reset at iteration 10 of a MULTU.
        @(negedge clk);
        op = 2'd1; a = 32'hFFFFFFFF; b = 32'h12345678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset busy", {31'd0, busy}, 32'd0);
        check("areset done", {31'd0, done}, 32'd0);
        check("areset hi", hi, 32'd0);
        check("areset lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("areset no_late_done", extra, 32'd0);
        check("areset hi held", hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
